stream_burst_reader: RTL and testbench



---
 rtl/stream_burst_reader_pkg.sv | 14 +
 rtl/stream_burst_reader.sv | 107 ++++++++++
 tb/tb_stream_burst_reader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_burst_reader_pkg.sv
// stream_burst_reader_pkg: shared FSM state type and width helper for the burst reader
package stream_burst_reader_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } burst_state_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int bits_for(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stream_burst_reader.sv
// stream_burst_reader: releases FIFO read-side data only in whole, framed bursts
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   din_*       FIFO read side: valid, ready (pop), data, used (occupancy)
//   dout_*      burst stream: valid, ready, data, last, len (held for the burst)
//
// Optional: define STREAM_BURST_READER_TIMEOUT_EN to flush a partial burst
// after Timeout idle cycles with a non-empty FIFO below BurstLen words.
module stream_burst_reader
    import stream_burst_reader_pkg::*;
#(
    parameter int Width    = 8,
    parameter int Depth    = 1024,
    parameter int BurstLen = 64,
    parameter int Timeout  = 4096,
    localparam int UsedBits = bits_for(Depth),
    localparam int LenBits  = bits_for(BurstLen)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [Width-1:0]    din_data,
    input  logic [UsedBits-1:0] din_used,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [Width-1:0]    dout_data,
    output logic                dout_last,
    output logic [LenBits-1:0]  dout_len
);

    localparam logic [UsedBits-1:0] FullUsed = UsedBits'(BurstLen);
    localparam logic [LenBits-1:0]  FullLen  = LenBits'(BurstLen);

    burst_state_t         state;
    logic [LenBits-1:0]   remain;
    logic                 in_burst;
    logic                 fire;

    // Pass-throughs are gated only by registered state, so the FIFO is
    // popped exactly when the downstream accepts a word.
    always_comb begin
        in_burst   = state == S_BURST;
        din_ready  = in_burst & dout_ready;
        dout_valid = in_burst & din_valid;
        dout_data  = din_data;
        dout_last  = in_burst & (remain == LenBits'(1));
        fire       = dout_valid & dout_ready;
    end

`ifdef STREAM_BURST_READER_TIMEOUT_EN
    localparam int                 CntBits = bits_for(Timeout);
    localparam logic [CntBits-1:0] CntMax  = CntBits'(Timeout - 1);

    logic [CntBits-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            remain   <= '0;
            dout_len <= '0;
            idle_cnt <= '0;
        end else if (!in_burst) begin
            if (din_used >= FullUsed) begin
                state    <= S_BURST;
                remain   <= FullLen;
                dout_len <= FullLen;
                idle_cnt <= '0;
            end else if (din_used == '0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == CntMax) begin
                // Partial flush: din_used < BurstLen here, so it fits LenBits.
                state    <= S_BURST;
                remain   <= din_used[LenBits-1:0];
                dout_len <= din_used[LenBits-1:0];
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CntBits'(1);
            end
        end else if (fire) begin
            remain <= remain - LenBits'(1);
            if (dout_last)
                state <= S_IDLE;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            remain   <= '0;
            dout_len <= '0;
        end else if (!in_burst) begin
            if (din_used >= FullUsed) begin
                state    <= S_BURST;
                remain   <= FullLen;
                dout_len <= FullLen;
            end
        end else if (fire) begin
            remain <= remain - LenBits'(1);
            if (dout_last)
                state <= S_IDLE;
        end
    end
`endif

endmodule

// File: tb/tb_stream_burst_reader.sv
// tb_stream_burst_reader: directed bench with a FIFO environment and a burst-level reference model
module tb_stream_burst_reader;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int BL = 4;
    localparam int TO = 8;
    localparam int UB = $clog2(D + 1);
    localparam int LB = $clog2(BL + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          din_valid;
    logic          din_ready;
    logic [W-1:0]  din_data;
    logic [UB-1:0] din_used;
    logic          dout_valid;
    logic          dout_ready;
    logic [W-1:0]  dout_data;
    logic          dout_last;
    logic [LB-1:0] dout_len;

    stream_burst_reader #(
        .Width(W), .Depth(D), .BurstLen(BL), .Timeout(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .din_used(din_used),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_last(dout_last), .dout_len(dout_len)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic [W-1:0] fifo[$];

    // Reference model: burst in progress, words left, advertised length.
    bit m_busy = 1'b0;
    int m_rem  = 0;
    int m_len  = 0;
    int m_cnt  = 0;

    // Log of accepted words.
    logic [W-1:0] acc_data[$];
    bit           acc_last[$];
    int           acc_len[$];
    int           acc_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_din();
        din_valid = fifo.size() > 0;
        din_data  = fifo.size() > 0 ? fifo[0] : '0;
        din_used  = UB'(fifo.size());
    endtask

    task automatic clear_log();
        acc_data.delete();
        acc_last.delete();
        acc_len.delete();
        acc_cyc.delete();
    endtask

    task automatic push(input logic [W-1:0] v);
        fifo.push_back(v);
        drive_din();
    endtask

    // One clock: compare at the falling edge, then advance FIFO and model.
    task automatic cycle();
        bit ev;
        bit fire;
        bit pop;
        bit rs;
        int used;
        @(negedge clk);
        ev = m_busy && fifo.size() > 0;
        check("dout_valid", 32'(dout_valid), 32'(ev));
        check("din_ready", 32'(din_ready), 32'(m_busy && dout_ready));
        check("dout_last", 32'(dout_last), 32'(m_busy && m_rem == 1));
        check("dout_len", 32'(dout_len), 32'(m_len));
        if (ev)
            check("dout_data", 32'(dout_data), 32'(fifo[0]));
        if (dout_valid && dout_ready) begin
            acc_data.push_back(dout_data);
            acc_last.push_back(dout_last);
            acc_len.push_back(int'(dout_len));
            acc_cyc.push_back(cyc);
        end
        fire = ev && dout_ready;
        pop  = din_ready && fifo.size() > 0;
        used = fifo.size();
        rs   = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (pop)
            void'(fifo.pop_front());
        if (rs) begin
            m_busy = 1'b0; m_rem = 0; m_len = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (used >= BL) begin
                m_busy = 1'b1; m_rem = BL; m_len = BL; m_cnt = 0;
            end
`ifdef STREAM_BURST_READER_TIMEOUT_EN
            else if (used == 0) m_cnt = 0;
            else if (m_cnt == TO - 1) begin
                m_busy = 1'b1; m_rem = used; m_len = used; m_cnt = 0;
            end else m_cnt++;
`endif
        end else if (fire) begin
            m_rem--;
            if (m_rem == 0)
                m_busy = 1'b0;
        end
        drive_din();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            cycle();
    endtask

    initial begin
        int t0;
        rst        = 1'b1;
        dout_ready = 1'b1;
        drive_din();
        @(posedge clk);
        #1;
        run(2);
        #1;
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_dout_last", 32'(dout_last), 32'd0);
        check("rst_dout_len", 32'(dout_len), 32'd0);
        rst = 1'b0;

        // Full burst: A1..A4 on consecutive cycles, one cycle after used=4.
        clear_log();
        for (int i = 1; i <= 4; i++)
            push(8'hA0 + 8'(i));
        t0 = cyc;
        run(7);
        check("full_count", 32'(acc_data.size()), 32'd4);
        if (acc_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("full_data", 32'(acc_data[i]), 32'(8'hA1 + 8'(i)));
                check("full_last", 32'(acc_last[i]), 32'(i == 3));
                check("full_len", 32'(acc_len[i]), 32'd4);
                check("full_cycle", 32'(acc_cyc[i] - t0), 32'(i + 1));
            end
        end

        // Backpressure: ready toggles during the burst.
        clear_log();
        for (int i = 1; i <= 4; i++)
            push(8'hB0 + 8'(i));
        cycle();
        for (int i = 0; i < 10; i++) begin
            dout_ready = (i % 2) == 0;
            cycle();
        end
        dout_ready = 1'b1;
        run(2);
        check("bp_count", 32'(acc_data.size()), 32'd4);
        if (acc_data.size() == 4)
            for (int i = 0; i < 4; i++) begin
                check("bp_data", 32'(acc_data[i]), 32'(8'hB1 + 8'(i)));
                check("bp_last", 32'(acc_last[i]), 32'(i == 3));
            end
        check("bp_fifo_empty", 32'(fifo.size()), 32'd0);

        // Excess occupancy: 10 words give two bursts of 4 and leave 2.
        clear_log();
        for (int i = 0; i < 10; i++)
            push(8'hC0 + 8'(i));
        run(14);
        check("ex_count", 32'(acc_data.size()), 32'd8);
        if (acc_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("ex_data", 32'(acc_data[i]), 32'(8'hC0 + 8'(i)));
                check("ex_last", 32'(acc_last[i]), 32'(i == 3 || i == 7));
            end
            check("ex_gap", 32'(acc_cyc[4] - acc_cyc[3] >= 2), 32'd1);
        end
        check("ex_leftover", 32'(fifo.size()), 32'd2);
`ifndef STREAM_BURST_READER_TIMEOUT_EN
        run(20);
        check("ex_no_third", 32'(acc_data.size()), 32'd8);
        check("ex_still_left", 32'(fifo.size()), 32'd2);
`endif
        push(8'hD0);
        push(8'hD1);
        run(8);
        check("ex_drained", 32'(fifo.size()), 32'd0);

`ifdef STREAM_BURST_READER_TIMEOUT_EN
        // Timeout: 3 words flush as a partial burst after TO idle cycles.
        run(3);
        clear_log();
        push(8'h31); push(8'h32); push(8'h33);
        t0 = cyc;
        run(TO + 6);
        check("to_count", 32'(acc_data.size()), 32'd3);
        if (acc_data.size() == 3) begin
            check("to_start", 32'(acc_cyc[0] - t0), 32'(TO));
            for (int i = 0; i < 3; i++) begin
                check("to_data", 32'(acc_data[i]), 32'(8'h31 + 8'(i)));
                check("to_last", 32'(acc_last[i]), 32'(i == 2));
                check("to_len", 32'(acc_len[i]), 32'd3);
            end
        end
`endif

        // Reset mid-burst after two words.
        clear_log();
        for (int i = 1; i <= 4; i++)
            push(8'hE0 + 8'(i));
        run(3);
        rst = 1'b1;
        cycle();
        #1;
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_ready", 32'(din_ready), 32'd0);
        check("mid_rst_len", 32'(dout_len), 32'd0);
        check("mid_rst_no_last", 32'(acc_last.size() > 0 && acc_last[acc_last.size()-1]), 32'd0);
        rst = 1'b0;
        run(2);
        clear_log();
        for (int i = 1; i <= 4; i++)
            push(8'hF0 + 8'(i));
        run(8);
        check("restart_count", 32'(acc_data.size()), 32'd4);
        if (acc_data.size() == 4)
            for (int i = 0; i < 4; i++)
                check("restart_last", 32'(acc_last[i]), 32'(i == 3));
        check("restart_left", 32'(fifo.size()), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
